// File: rtl/toast_definitions.sv
// Shared definitions for the TOAST execute stage.
// Holds the ALU and MEM op encodings, the divider FSM states,
// the forwarding select codes and the control bundle that
// travels from EX to MEM. It also has small helpers that decode
// the divide ops.
package toast_definitions;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_DIV   = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REM   = 4'd13,
        ALU_REMU  = 4'd14
    } alu_op_e;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Forwarding select codes. 2'b00 and 2'b11 both pick the ID operand.
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // These are the control fields that travel with an instruction into MEM.
    typedef struct packed {
        logic       mem_wr_en;
        logic [3:0] mem_op;
        logic       memtoreg;
        logic       rd_wr_en;
        logic [4:0] rd_addr;
        logic       exception;
    } ex_ctrl_t;

    function automatic logic is_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input alu_op_e op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/toast_divider.sv
// Iterative unsigned restoring divider. It produces one quotient bit per cycle.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   start              : load the operands and begin. Sampled only in IDLE.
//   abort              : return to IDLE from any state
//   dividend, divisor  : unsigned magnitudes to divide
//   busy               : high while the 32 iterations run
//   done               : high for the one cycle after the iterations finish
//   quotient, remainder: unsigned result. Valid while done is high.
module toast_divider
    import toast_definitions::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [XLEN:0]   shifted, trial;

    // The partial remainder is shifted left by one and the next dividend bit
    // comes in. The shifted value is always below 2*divisor, so bit XLEN of
    // the trial difference is the borrow.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // NOTE: every signal written here gets a default first, so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = DIV_BUSY;
            DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (abort) state_d = DIV_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so that every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DIV_IDLE && start && !abort) begin
                cnt_q <= '0;
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
            end else if (state_q == DIV_BUSY) begin
                cnt_q <= cnt_q + 5'd1;
                if (!trial[XLEN]) begin
                    rem_q <= trial[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/toast_ex_stage.sv
// TOAST execute stage: operand forwarding, a single-cycle ALU and a 34-cycle
// iterative divide, with registered outputs to the MEM stage.
// Ports:
//   clk_i, reset_i                    : clock and synchronous active-high reset
//   ID_*_i                            : operands and control from ID/EX
//   ForwardA_i, ForwardB_i            : operand source select
//   MEM_alu_result_i, WB_rd_data_i    : forwarded values
//   flush_i                           : kill the instruction in EX, including a running divide
//   EX_stall_o                        : freeze IF/ID while a divide occupies EX
//   EX_*_o                            : registered result and control to MEM
module toast_ex_stage
    import toast_definitions::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] ID_rs1_data_i,
    input  logic [XLEN-1:0] ID_rs2_data_i,
    input  logic [XLEN-1:0] ID_imm_i,
    input  logic [3:0]      ID_alu_ctrl_i,
    input  logic            ID_alu_src_i,
    input  logic            ID_valid_i,
    input  logic            ID_mem_wr_en_i,
    input  logic [3:0]      ID_mem_op_i,
    input  logic            ID_memtoreg_i,
    input  logic            ID_rd_wr_en_i,
    input  logic [4:0]      ID_rd_addr_i,
    input  logic            ID_exception_i,
    input  logic [1:0]      ForwardA_i,
    input  logic [1:0]      ForwardB_i,
    input  logic [XLEN-1:0] MEM_alu_result_i,
    input  logic [XLEN-1:0] WB_rd_data_i,
    input  logic            flush_i,
    output logic            EX_stall_o,
    output logic [XLEN-1:0] EX_alu_result_o,
    output logic [XLEN-1:0] EX_rs2_data_o,
    output logic            EX_mem_wr_en_o,
    output logic [3:0]      EX_mem_op_o,
    output logic            EX_memtoreg_o,
    output logic            EX_rd_wr_en_o,
    output logic [4:0]      EX_rd_addr_o,
    output logic            EX_exception_o
);

    alu_op_e         op;
    ex_ctrl_t        id_ctrl, ex_ctrl_q, cap_ctrl_q;
    logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_result;
    logic [XLEN-1:0] mag_a, mag_b, div_q, div_r, q_fix, r_fix;
    logic [XLEN-1:0] alu_result_q, rs2_q, cap_rs2_q;
    logic            is_div, sgn_div, div_zero, div_ovf, div_bypass, accept;
    logic            div_busy, div_done;
    logic            cap_q_neg, cap_r_neg, cap_is_rem;

    assign op      = alu_op_e'(ID_alu_ctrl_i);
    assign id_ctrl = '{mem_wr_en: ID_mem_wr_en_i, mem_op: ID_mem_op_i,
                       memtoreg: ID_memtoreg_i, rd_wr_en: ID_rd_wr_en_i,
                       rd_addr: ID_rd_addr_i, exception: ID_exception_i};

    always_comb begin
        case (ForwardA_i)
            FWD_MEM: op_a = MEM_alu_result_i;
            FWD_WB:  op_a = WB_rd_data_i;
            default: op_a = ID_rs1_data_i;
        endcase
        case (ForwardB_i)
            FWD_MEM: rs2_fwd = MEM_alu_result_i;
            FWD_WB:  rs2_fwd = WB_rd_data_i;
            default: rs2_fwd = ID_rs2_data_i;
        endcase
    end

    assign op_b = ID_alu_src_i ? ID_imm_i : rs2_fwd;

    // Division by zero and signed overflow have fixed answers, so these
    // cases finish in one cycle and never start the iterative divider.
    assign is_div     = is_div_op(op);
    assign sgn_div    = is_signed_div_op(op);
    assign div_zero   = (op_b == '0);
    assign div_ovf    = sgn_div && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign div_bypass = div_zero || div_ovf;
    assign accept     = !div_busy && !div_done && ID_valid_i && is_div && !flush_i && !div_bypass;
    assign EX_stall_o = accept || div_busy || div_done;

    assign mag_a = (sgn_div && op_a[XLEN-1]) ? -op_a : op_a;
    assign mag_b = (sgn_div && op_b[XLEN-1]) ? -op_b : op_b;

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_SLL:   alu_result = op_a << op_b[4:0];
            ALU_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_result = {31'd0, op_a < op_b};
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SRL:   alu_result = op_a >> op_b[4:0];
            ALU_SRA:   alu_result = $signed(op_a) >>> op_b[4:0];
            ALU_OR:    alu_result = op_a | op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_PASSB: alu_result = op_b;
            // Only the bypass answers reach the output register. An iterated
            // divide leaves a bubble until the divider is done.
            ALU_DIV, ALU_DIVU: alu_result = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            ALU_REM, ALU_REMU: alu_result = div_zero ? op_a : 32'h0;
            default:   alu_result = '0;
        endcase
    end

    toast_divider u_divider (
        .clk       (clk_i),
        .reset     (reset_i),
        .start     (accept),
        .abort     (flush_i),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // The quotient truncates toward zero. The remainder takes the sign of the dividend.
    assign q_fix = cap_q_neg ? -div_q : div_q;
    assign r_fix = cap_r_neg ? -div_r : div_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cap_ctrl_q <= '0;
            cap_rs2_q  <= '0;
            cap_q_neg  <= 1'b0;
            cap_r_neg  <= 1'b0;
            cap_is_rem <= 1'b0;
        end else if (accept) begin
            cap_ctrl_q <= id_ctrl;
            cap_rs2_q  <= rs2_fwd;
            cap_q_neg  <= sgn_div && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            cap_r_neg  <= sgn_div && op_a[XLEN-1];
            cap_is_rem <= is_rem_op(op);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_ctrl_q    <= '0;
            alu_result_q <= '0;
            rs2_q        <= '0;
        end else if (flush_i) begin
            ex_ctrl_q    <= '0;
            alu_result_q <= '0;
            rs2_q        <= '0;
        end else if (div_done) begin
            ex_ctrl_q    <= cap_ctrl_q;
            alu_result_q <= cap_is_rem ? r_fix : q_fix;
            rs2_q        <= cap_rs2_q;
        end else if (EX_stall_o || !ID_valid_i) begin
            ex_ctrl_q    <= '0;
            alu_result_q <= '0;
            rs2_q        <= '0;
        end else begin
            ex_ctrl_q    <= id_ctrl;
            alu_result_q <= alu_result;
            rs2_q        <= rs2_fwd;
        end
    end

    assign EX_alu_result_o = alu_result_q;
    assign EX_rs2_data_o   = rs2_q;
    assign EX_mem_wr_en_o  = ex_ctrl_q.mem_wr_en;
    assign EX_mem_op_o     = ex_ctrl_q.mem_op;
    assign EX_memtoreg_o   = ex_ctrl_q.memtoreg;
    assign EX_rd_wr_en_o   = ex_ctrl_q.rd_wr_en;
    assign EX_rd_addr_o    = ex_ctrl_q.rd_addr;
    assign EX_exception_o  = ex_ctrl_q.exception;

endmodule

// File: tb/tb_toast_ex_stage.sv
// Directed testbench for toast_ex_stage. Every expected value below is
// worked out by hand from the behaviour of the stage.
module tb_toast_ex_stage;
    import toast_definitions::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] ID_rs1_data_i, ID_rs2_data_i, ID_imm_i;
    logic [3:0]  ID_alu_ctrl_i;
    logic        ID_alu_src_i, ID_valid_i, ID_mem_wr_en_i, ID_memtoreg_i;
    logic        ID_rd_wr_en_i, ID_exception_i;
    logic [3:0]  ID_mem_op_i;
    logic [4:0]  ID_rd_addr_i;
    logic [1:0]  ForwardA_i, ForwardB_i;
    logic [31:0] MEM_alu_result_i, WB_rd_data_i;
    logic        flush_i;
    logic        EX_stall_o;
    logic [31:0] EX_alu_result_o, EX_rs2_data_o;
    logic        EX_mem_wr_en_o, EX_memtoreg_o, EX_rd_wr_en_o, EX_exception_o;
    logic [3:0]  EX_mem_op_o;
    logic [4:0]  EX_rd_addr_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    toast_ex_stage dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .ID_rs1_data_i    (ID_rs1_data_i),
        .ID_rs2_data_i    (ID_rs2_data_i),
        .ID_imm_i         (ID_imm_i),
        .ID_alu_ctrl_i    (ID_alu_ctrl_i),
        .ID_alu_src_i     (ID_alu_src_i),
        .ID_valid_i       (ID_valid_i),
        .ID_mem_wr_en_i   (ID_mem_wr_en_i),
        .ID_mem_op_i      (ID_mem_op_i),
        .ID_memtoreg_i    (ID_memtoreg_i),
        .ID_rd_wr_en_i    (ID_rd_wr_en_i),
        .ID_rd_addr_i     (ID_rd_addr_i),
        .ID_exception_i   (ID_exception_i),
        .ForwardA_i       (ForwardA_i),
        .ForwardB_i       (ForwardB_i),
        .MEM_alu_result_i (MEM_alu_result_i),
        .WB_rd_data_i     (WB_rd_data_i),
        .flush_i          (flush_i),
        .EX_stall_o       (EX_stall_o),
        .EX_alu_result_o  (EX_alu_result_o),
        .EX_rs2_data_o    (EX_rs2_data_o),
        .EX_mem_wr_en_o   (EX_mem_wr_en_o),
        .EX_mem_op_o      (EX_mem_op_o),
        .EX_memtoreg_o    (EX_memtoreg_o),
        .EX_rd_wr_en_o    (EX_rd_wr_en_o),
        .EX_rd_addr_o     (EX_rd_addr_o),
        .EX_exception_o   (EX_exception_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven and registered outputs are stable.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bubble();
        ID_valid_i     = 1'b0;
        ID_rd_wr_en_i  = 1'b0;
        ID_mem_wr_en_i = 1'b0;
        ID_memtoreg_i  = 1'b0;
        ID_exception_i = 1'b0;
        ID_mem_op_i    = 4'd0;
        ID_rd_addr_i   = 5'd0;
        ForwardA_i     = 2'b00;
        ForwardB_i     = 2'b00;
        ID_alu_src_i   = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ID_valid_i     = 1'b1;
        ID_alu_ctrl_i  = op;
        ID_rs1_data_i  = a;
        ID_rs2_data_i  = b;
        ID_imm_i       = 32'h0;
        ID_alu_src_i   = 1'b0;
        ID_rd_wr_en_i  = 1'b1;
        ID_rd_addr_i   = 5'd9;
        ID_mem_op_i    = 4'd3;
        ID_memtoreg_i  = 1'b0;
        ID_mem_wr_en_i = 1'b0;
        ID_exception_i = 1'b0;
        ForwardA_i     = 2'b00;
        ForwardB_i     = 2'b00;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        tick();
        check(tag, EX_alu_result_o, exp);
        bubble();
    endtask

    // The instruction is held on the inputs, as a frozen IF/ID would hold it, until its
    // result appears. The cycles with stall high are counted.
    task automatic div_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int  n;
        bit  got;
        n   = 0;
        got = 0;
        issue(op, a, b);
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (EX_stall_o) n++;
            tick();
            if (EX_rd_wr_en_o) got = 1;
        end
        bubble();
        check({tag, "_arrived"}, 32'(got), 32'd1);
        check({tag, "_stall_cycles"}, n, exp_stall);
        check({tag, "_result"}, EX_alu_result_o, exp);
        check({tag, "_rd_addr"}, 32'(EX_rd_addr_o), 32'd9);
        #1;
        check({tag, "_stall_after"}, 32'(EX_stall_o), 32'd0);
    endtask

    initial begin
        reset_i          = 1'b1;
        flush_i          = 1'b0;
        MEM_alu_result_i = 32'h0;
        WB_rd_data_i     = 32'h0;
        ID_rs1_data_i    = 32'h0;
        ID_rs2_data_i    = 32'h0;
        ID_imm_i         = 32'h0;
        ID_alu_ctrl_i    = 4'd0;
        bubble();
        tick();
        tick();
        check("reset_result", EX_alu_result_o, 32'h0);
        check("reset_rd_wr_en", 32'(EX_rd_wr_en_o), 32'd0);
        check("reset_stall", 32'(EX_stall_o), 32'd0);
        reset_i = 1'b0;

        // ADD needs one cycle and must not stall.
        issue(ALU_ADD, 32'd5, 32'd7);
        #1;
        check("add_stall", 32'(EX_stall_o), 32'd0);
        tick();
        check("add_result", EX_alu_result_o, 32'd12);
        check("add_rd_wr_en", 32'(EX_rd_wr_en_o), 32'd1);
        check("add_rs2", EX_rs2_data_o, 32'd7);
        bubble();

        alu_vec("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_vec("sll", ALU_SLL, 32'd1, 32'd33, 32'd2);
        alu_vec("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_vec("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_vec("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_vec("xor", ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        alu_vec("or", ALU_OR, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101);
        alu_vec("and", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
        alu_vec("passb", ALU_PASSB, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // The ADD takes rs1 forwarded from MEM and B from the immediate, and rs2 from WB.
        issue(ALU_ADD, 32'hDEAD_BEEF, 32'h5555_5555);
        ForwardA_i       = 2'b01;
        ForwardB_i       = 2'b10;
        MEM_alu_result_i = 32'h100;
        WB_rd_data_i     = 32'hABCD_0001;
        ID_imm_i         = 32'd4;
        ID_alu_src_i     = 1'b1;
        ID_exception_i   = 1'b1;
        ID_mem_wr_en_i   = 1'b1;
        tick();
        check("fwd_result", EX_alu_result_o, 32'h104);
        check("fwd_rs2", EX_rs2_data_o, 32'hABCD_0001);
        check("fwd_exception", 32'(EX_exception_o), 32'd1);
        check("fwd_mem_wr_en", 32'(EX_mem_wr_en_o), 32'd1);
        check("fwd_mem_op", 32'(EX_mem_op_o), 32'd3);
        bubble();

        // A valid=0 bubble registers zeros even when the fields are set.
        ID_rd_wr_en_i = 1'b1;
        ID_exception_i = 1'b1;
        tick();
        check("bubble_rd_wr_en", 32'(EX_rd_wr_en_o), 32'd0);
        check("bubble_exception", 32'(EX_exception_o), 32'd0);
        bubble();

        div_vec("div_s", ALU_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
        div_vec("rem_s", ALU_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
        div_vec("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
        div_vec("remu", ALU_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 34);
        div_vec("divu_zero", ALU_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
        div_vec("remu_zero", ALU_REMU, 32'd7, 32'd0, 32'd7, 0);
        div_vec("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        div_vec("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

        // A flush 10 cycles into a divide drops the stall on the next cycle and leaves a bubble.
        issue(ALU_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bubble();
        #1;
        check("flush_stall", 32'(EX_stall_o), 32'd0);
        check("flush_rd_wr_en", 32'(EX_rd_wr_en_o), 32'd0);
        issue(ALU_ADD, 32'd3, 32'd4);
        tick();
        check("flush_next_add", EX_alu_result_o, 32'd7);
        bubble();

        // A reset 10 cycles into a divide aborts it and clears every output.
        issue(ALU_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        bubble();
        #1;
        check("rst_stall", 32'(EX_stall_o), 32'd0);
        check("rst_result", EX_alu_result_o, 32'h0);
        check("rst_rd_addr", 32'(EX_rd_addr_o), 32'd0);
        check("rst_mem_op", 32'(EX_mem_op_o), 32'd0);
        issue(ALU_ADD, 32'd20, 32'd22);
        tick();
        check("rst_next_add", EX_alu_result_o, 32'd42);
        bubble();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toast_ex_stage.md
TOAST_EX_STAGE -- requirements
Module: toast_ex_stage

Interface
REQ-001 SHALL have clk_i  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have reset_i  in  1  synchronous, active-high reset.
REQ-003 SHALL have operand inputs ID_rs1_data_i, ID_rs2_data_i, ID_imm_i  in  32  register file operands and sign-extended immediate.
REQ-004 SHALL have ID_alu_ctrl_i  in  4  ALU op select: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, DIV, DIVU, REM, REMU.
REQ-005 SHALL have ID_alu_src_i  in  1  operand B select: 1 = immediate, 0 = rs2.
REQ-006 SHALL have ID_valid_i  in  1  instruction present; 0 = bubble.
REQ-007 SHALL have ID_mem_wr_en_i (1), ID_mem_op_i (4), ID_memtoreg_i (1), ID_rd_wr_en_i (1), ID_rd_addr_i (5), ID_exception_i (1)  in  control fields passed to MEM.
REQ-008 SHALL have ForwardA_i, ForwardB_i  in  2  operand source: 00 = ID, 01 = MEM_alu_result_i, 10 = WB_rd_data_i, 11 = ID.
REQ-009 SHALL have MEM_alu_result_i, WB_rd_data_i  in  32  forwarded values.
REQ-010 SHALL have flush_i  in  1  kill the instruction in EX, including an in-flight divide.
REQ-011 SHALL have EX_stall_o  out  1  freeze IF/ID while a divide occupies EX.
REQ-012 SHALL have registered outputs EX_alu_result_o (32), EX_rs2_data_o (32), EX_mem_wr_en_o, EX_mem_op_o (4), EX_memtoreg_o, EX_rd_wr_en_o, EX_rd_addr_o (5), EX_exception_o  out  to MEM stage.

Function
REQ-013 Non-divide ops SHALL register their result and control fields at the edge ending the cycle they are presented, giving 1-cycle latency.
REQ-014 Operand B SHALL be the immediate when ID_alu_src_i=1, otherwise forwarded rs2; EX_rs2_data_o SHALL always carry forwarded rs2.
REQ-015 Shift amount SHALL be B[4:0]; SLT is signed and SLTU is unsigned, both giving 0/1; all arithmetic wraps modulo 2^32.
REQ-016 The divider FSM SHALL have states IDLE, BUSY, DONE.
REQ-017 The FSM SHALL go IDLE->BUSY on ID_valid_i & divide op & ~flush_i, capturing operands, signs and control fields.
REQ-018 The FSM SHALL stay in BUSY for 32 restoring iterations, one quotient bit per cycle, then go BUSY->DONE.
REQ-019 In DONE the block SHALL sign-correct the result, register it with the captured control fields, and return to IDLE.
REQ-020 EX_stall_o SHALL be combinationally high from the accept cycle T through T+33, and low in every other cycle.
REQ-021 The divide result SHALL register at the edge ending T+33.
REQ-022 While EX_stall_o is high, EX outputs SHALL register bubbles (rd_wr_en=0, mem_wr_en=0, memtoreg=0) until the result edge.
REQ-023 Divide by zero SHALL bypass the iteration (no stall, 1-cycle): quotient=0xFFFFFFFF; remainder=dividend.
REQ-024 Signed overflow (0x80000000 / -1) SHALL bypass the iteration (no stall, 1-cycle): quotient=0x80000000, remainder=0.
REQ-025 The remainder sign SHALL follow the dividend; the quotient SHALL truncate toward zero.
REQ-026 flush_i in any state SHALL return the FSM to IDLE, drop EX_stall_o next cycle, and register a bubble.
REQ-027 ID_valid_i=0 SHALL register a bubble; EX_exception_o SHALL equal ID_exception_i of the registered instruction.

Reset
REQ-028 reset_i SHALL clear all outputs and internal registers to 0 and force the FSM to IDLE.
REQ-029 reset_i asserted mid-divide SHALL abort it, with EX_stall_o=0 in the cycle after reset.

Structure
REQ-030 ALU op codes, MEM op codes and FSM state encodings SHALL live in the shared toast_definitions package.
REQ-031 The iterative divider SHALL be a sub-module, toast_divider, with start/busy/done handshake, operands in and quotient/remainder out.

Verification
REQ-032 Scenario ADD: rs1=5, rs2=7 -> EX_alu_result_o=12 one cycle later, EX_stall_o never high.
REQ-033 Scenario signed divide: DIV -20/3 -> stall high 34 cycles, result 0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2).
REQ-034 Scenario divide by zero: DIVU 7/0 -> 0xFFFFFFFF in 1 cycle, no stall; REMU 7/0 -> 7.
REQ-035 Scenario overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle, no stall.
REQ-036 Scenario flush/reset mid-divide: flush_i at T+10 -> EX_stall_o=0 at T+11, bubble out, next ADD correct; repeat with reset_i -> all outputs 0.
REQ-037 Scenario forwarding: ForwardA=01 with MEM_alu_result_i=0x100 and imm=4 -> ADD result 0x104.
